mem_wb_stage: RTL and testbench

- Producer end of the MEM→WB boundary: MEM/WB pipeline register that drives `mem_to_wb_if` through the `to_write_back` modport.
- Issues data-memory requests for loads and stores, and stalls the upstream pipeline while memory is not ready.
- Aligns and sign/zero-extends load data, and inserts bubbles on stall, flush and timeout.

---
 rtl/mem_wb_stage_pkg.sv | 11 +
 rtl/mem_to_wb_if.sv | 11 +
 rtl/mem_wb_stage_load_aligner.sv | 20 ++
 rtl/mem_wb_stage.sv | 64 ++++++
 tb/tb_mem_wb_stage.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared types and load-width encodings for the MEM/WB boundary
package mem_wb_stage_pkg;
   typedef logic [31:0] data_t;
   typedef enum logic [1:0] {RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2} result_src_t;
   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_wait_state_t;
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
endpackage

// File: rtl/mem_to_wb_if.sv
// mem_to_wb_if: registered MEM->WB pipeline fields
interface mem_to_wb_if;
   import mem_wb_stage_pkg::*;
   result_src_t cfsm__result_src;
   logic        RegWriteW;
   data_t       read_data;
   data_t       alu_result;
   logic [4:0]  rd;
   modport to_write_back (output cfsm__result_src, RegWriteW, read_data, alu_result, rd);
   modport from_mem (input cfsm__result_src, RegWriteW, read_data, alu_result, rd);
endinterface

// File: rtl/mem_wb_stage_load_aligner.sv
// load_aligner: selects the addressed byte/half of a memory word and extends it
module load_aligner
   import mem_wb_stage_pkg::*;
(
   input  data_t      word,
   input  logic [1:0] off,
   input  logic [2:0] funct3,
   output data_t      data
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      data = funct3 == LB  ? {{24{b[7]}}, b} :
             funct3 == LBU ? {24'd0, b} :
             funct3 == LH  ? {{16{h[15]}}, h} :
             funct3 == LHU ? {16'd0, h} : word;
   end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB register with data-memory handshake, stall and timeout
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int WAIT_LIMIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_m,
   input  result_src_t result_src_m,
   input  logic        reg_write_m,
   input  data_t       alu_result_m,
   input  logic [4:0]  rd_m,
   input  logic        mem_read_m,
   input  logic        mem_write_m,
   input  logic [2:0]  funct3_m,
   input  logic        flush,
   output logic        dmem_req,
   input  logic        dmem_ready,
   input  data_t       dmem_rdata,
   output logic        stall_m,
   output logic        mem_err,
   mem_to_wb_if.to_write_back wb
);
   localparam int CW = $clog2(WAIT_LIMIT);
   mem_wait_state_t state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            access, timeout, capture;
   data_t           aligned;
   load_aligner u_align (.word(dmem_rdata), .off(alu_result_m[1:0]), .funct3(funct3_m), .data(aligned));
   assign access  = valid_m & (mem_read_m | mem_write_m);
   assign timeout = (state == WAIT) & ~dmem_ready & (cnt == CW'(WAIT_LIMIT - 1));
   assign capture = ~flush & (state == WAIT ? dmem_ready : valid_m & (~access | dmem_ready));
   // gated by rst_n so both drop the instant reset asserts, even with a load still presented
   assign dmem_req = rst_n & ~flush & (state == WAIT | access);
   assign stall_m  = rst_n & ~flush & ~dmem_ready & (state == WAIT ? ~timeout : access);
   always_comb begin
      state_n = flush ? IDLE :
                state == IDLE ? (access & ~dmem_ready ? WAIT : IDLE) :
                (dmem_ready | timeout) ? IDLE : WAIT;
      cnt_n = (flush | state == IDLE) ? '0 : cnt + 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= IDLE;
         cnt                 <= '0;
         mem_err             <= 1'b0;
         wb.cfsm__result_src <= RES_ALU;
         wb.RegWriteW        <= 1'b0;
         wb.read_data        <= '0;
         wb.alu_result       <= '0;
         wb.rd               <= '0;
      end else begin
         state               <= state_n;
         cnt                 <= cnt_n;
         mem_err             <= mem_err | (timeout & ~flush);
         wb.cfsm__result_src <= capture ? result_src_m : RES_ALU;
         wb.RegWriteW        <= capture & reg_write_m;
         wb.read_data        <= capture & mem_read_m ? aligned : '0;
         wb.alu_result       <= capture ? alu_result_m : '0;
         wb.rd               <= capture ? rd_m : '0;
      end
   end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;
   import mem_wb_stage_pkg::*;
   typedef struct packed {
      result_src_t src;
      logic        rw;
      logic [4:0]  rd;
      data_t       rdata;
      data_t       alu;
   } wb_t;
   localparam wb_t BUB = '0;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_m = 1'b0;
   result_src_t result_src_m = RES_ALU;
   logic        reg_write_m = 1'b0;
   data_t       alu_result_m = '0;
   logic [4:0]  rd_m = '0;
   logic        mem_read_m = 1'b0;
   logic        mem_write_m = 1'b0;
   logic [2:0]  funct3_m = '0;
   logic        flush = 1'b0;
   logic        dmem_req;
   logic        dmem_ready = 1'b0;
   data_t       dmem_rdata = '0;
   logic        stall_m;
   logic        mem_err;
   int          n_chk = 0;
   int          n_pass = 0;
   wb_t         q[$];
   wb_t         obs;
   mem_to_wb_if wb_if ();
   mem_wb_stage #(.WAIT_LIMIT(15)) dut (
      .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .result_src_m(result_src_m),
      .reg_write_m(reg_write_m), .alu_result_m(alu_result_m), .rd_m(rd_m),
      .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .funct3_m(funct3_m),
      .flush(flush), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .stall_m(stall_m), .mem_err(mem_err),
      .wb(wb_if.to_write_back)
   );
   always #5 clk = ~clk;
   assign obs = {wb_if.cfsm__result_src, wb_if.RegWriteW, wb_if.rd, wb_if.read_data, wb_if.alu_result};
   task automatic chk(input string tag, input logic [71:0] o, input logic [71:0] e);
      n_chk++;
      assert (o === e) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, o, e);
   endtask
   task automatic set_in(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                         input data_t alu, input logic [4:0] rd, input logic rw, input result_src_t src);
      valid_m = v; mem_read_m = ld; mem_write_m = st; funct3_m = f3;
      alu_result_m = alu; rd_m = rd; reg_write_m = rw; result_src_m = src;
   endtask
   task automatic tick();
      wb_t e;
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk("wb", obs, e);
   endtask
   task automatic load0(input logic [2:0] f3, input data_t addr, input data_t want);
      set_in(1, 1, 0, f3, addr, 5'd1, 1, RES_MEM);
      dmem_ready = 1'b1;
      #3 chk("ld_stall", stall_m, 0);
      chk("ld_req", dmem_req, 1);
      q.push_back('{RES_MEM, 1'b1, 5'd1, want, addr});
      tick();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      set_in(1, 1, 0, LW, 32'h40, 5'd2, 1, RES_MEM);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb", obs, BUB);
      chk("rst_req", dmem_req, 0);
      chk("rst_stall", stall_m, 0);
      chk("rst_err", mem_err, 0);
      chk("rst_state", dut.state, IDLE);
      set_in(0, 0, 0, 0, 0, 0, 0, RES_ALU);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      set_in(1, 0, 0, 0, 32'h0000_1234, 5'd5, 1, RES_ALU);
      #3 chk("alu_stall", stall_m, 0);
      chk("alu_req", dmem_req, 0);
      q.push_back('{RES_ALU, 1'b1, 5'd5, 32'h0, 32'h0000_1234});
      tick();
      dmem_rdata = 32'h80FF_1234;
      load0(LB,  32'h103, 32'hFFFF_FF80);
      load0(LBU, 32'h103, 32'h0000_0080);
      load0(LH,  32'h102, 32'hFFFF_80FF);
      load0(LHU, 32'h100, 32'h0000_1234);
      load0(LW,  32'h103, 32'h80FF_1234);
      set_in(1, 0, 1, LW, 32'h200, 5'd0, 0, RES_ALU);
      #3 chk("st_req", dmem_req, 1);
      q.push_back('{RES_ALU, 1'b0, 5'd0, 32'h0, 32'h200});
      tick();
      set_in(1, 1, 0, LW, 32'h40, 5'd9, 1, RES_MEM);
      dmem_ready = 1'b0;
      dmem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         #3 chk("late_stall", stall_m, 1);
         chk("late_req", dmem_req, 1);
         q.push_back(BUB);
         tick();
      end
      dmem_ready = 1'b1;
      dmem_rdata = 32'h1122_3344;
      #3 chk("late_stall_end", stall_m, 0);
      chk("late_req_end", dmem_req, 1);
      q.push_back('{RES_MEM, 1'b1, 5'd9, 32'h1122_3344, 32'h40});
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, RES_ALU);
      #3 chk("idle_req", dmem_req, 0);
      q.push_back(BUB);
      tick();
      set_in(1, 1, 0, LW, 32'h80, 5'd10, 1, RES_MEM);
      dmem_ready = 1'b0;
      #3 chk("to_stall0", stall_m, 1);
      q.push_back(BUB);
      tick();
      for (int i = 1; i <= 15; i++) begin
         #3 chk("to_stall", stall_m, i < 15);
         chk("to_req", dmem_req, 1);
         q.push_back(BUB);
         tick();
         chk("to_err", mem_err, i == 15);
      end
      chk("to_state", dut.state, IDLE);
      set_in(0, 0, 0, 0, 0, 0, 0, RES_ALU);
      #3 chk("to_stall_after", stall_m, 0);
      q.push_back(BUB);
      tick();
      chk("to_err_sticky", mem_err, 1);
      set_in(1, 1, 0, LW, 32'h84, 5'd11, 1, RES_MEM);
      q.push_back(BUB);
      tick();
      #3 chk("fl_w1_stall", stall_m, 1);
      q.push_back(BUB);
      tick();
      flush = 1'b1;
      #3 chk("fl_req", dmem_req, 0);
      chk("fl_stall", stall_m, 0);
      q.push_back(BUB);
      tick();
      flush = 1'b0;
      set_in(1, 0, 0, 0, 32'h55, 5'd3, 1, RES_ALU);
      #3 chk("fl_alu_stall", stall_m, 0);
      chk("fl_alu_req", dmem_req, 0);
      q.push_back('{RES_ALU, 1'b1, 5'd3, 32'h0, 32'h55});
      tick();
      set_in(1, 1, 0, LW, 32'h88, 5'd12, 1, RES_MEM);
      q.push_back(BUB);
      tick();
      #2 chk("ar_stall_pre", stall_m, 1);
      #1 rst_n = 1'b0;
      #1 chk("ar_wb", obs, BUB);
      chk("ar_stall", stall_m, 0);
      chk("ar_req", dmem_req, 0);
      chk("ar_err", mem_err, 0);
      #2 rst_n = 1'b1;
      #1 chk("ar_state", dut.state, IDLE);
      set_in(0, 0, 0, 0, 0, 0, 0, RES_ALU);
      q.push_back(BUB);
      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
